// File: rtl/ins_dec_stage_if.sv
// ins_dec_stage_if: the stage's handshake and bus signals.
// The slave modport is the decode stage. The master modport is whoever
// drives instructions in, consumes decoded fields and reports write-back.
interface ins_dec_stage_if #(
    parameter int DW    = 4,
    parameter int RW    = 2,
    parameter int INS_W = 16
);
    logic [INS_W-1:0] INS;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic             sel_data;
    logic             write_en;
    logic             alu_op;
    logic             is_branch;
    logic [RW-1:0]    SEL_A;
    logic [RW-1:0]    SEL_B;
    logic [RW-1:0]    SEL_W;
    logic [DW-1:0]    IMM;
    logic [DW-1:0]    JMP;
    logic             stall;
    logic             wb_valid;
    logic [RW-1:0]    WB_SEL;

    modport slave (
        input  INS, in_valid, flush, out_ready, wb_valid, WB_SEL,
        output in_ready, out_valid, sel_data, write_en, alu_op, is_branch,
        output SEL_A, SEL_B, SEL_W, IMM, JMP, stall
    );

    modport master (
        output INS, in_valid, flush, out_ready, wb_valid, WB_SEL,
        input  in_ready, out_valid, sel_data, write_en, alu_op, is_branch,
        input  SEL_A, SEL_B, SEL_W, IMM, JMP, stall
    );
endinterface

// File: rtl/ins_dec_stage.sv
// ins_dec_stage: registered instruction-decode stage with a valid/ready
// handshake, a flush path for taken branches and an optional register
// scoreboard that holds RAW/WAW hazards until write-back.
// Optional feature macro: INS_DEC_SCOREBOARD_EN (undefined = no scoreboard,
// stall tied low, write-back inputs ignored).
module ins_dec_stage #(
    parameter int DW    = 4,
    parameter int RW    = 2,
    parameter int INS_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    ins_dec_stage_if.slave    bus
);
    localparam int NREG = 2 ** RW;

    logic [2:0]    op;
    logic          dec_sel_data;
    logic          dec_write_en;
    logic          dec_alu_op;
    logic          dec_is_branch;

    logic          full;
    logic          sel_data_q;
    logic          write_en_q;
    logic          alu_op_q;
    logic          is_branch_q;
    logic [RW-1:0] sel_a_q;
    logic [RW-1:0] sel_b_q;
    logic [RW-1:0] sel_w_q;
    logic [DW-1:0] imm_q;
    logic [DW-1:0] jmp_q;

    logic          stall_i;
    logic          out_valid_i;
    logic          in_ready_i;
    logic          xfer;
    logic          issue;
    logic          accept;

    // Bits above the opcode field are don't-care; fold them here so the
    // whole word is visibly consumed.
    logic          unused_ins;
    assign unused_ins = ^bus.INS;

    assign op = bus.INS[2*DW+2:2*DW];

    // Opcode decode of the incoming word
    always_comb begin
        dec_sel_data  = op[1];
        dec_alu_op    = op[0];
        dec_is_branch = (op == 3'b100);
        dec_write_en  = (op[2] | ~op[1] | ~op[0]) & (~op[2] | op[1] | op[0]);
    end

    assign out_valid_i = full & ~stall_i;
    assign xfer        = out_valid_i & bus.out_ready;
    // A flushed instruction never counts as issued, so it cannot mark its
    // destination pending.
    assign issue       = xfer & ~bus.flush;
    assign in_ready_i  = ~rst & (~full | xfer);
    assign accept      = bus.in_valid & in_ready_i & ~bus.flush;

    // Pipeline register: capture on accept, drop on issue or flush
    always_ff @(posedge clk) begin
        if (rst) begin
            full        <= 1'b0;
            sel_data_q  <= 1'b0;
            write_en_q  <= 1'b0;
            alu_op_q    <= 1'b0;
            is_branch_q <= 1'b0;
            sel_a_q     <= '0;
            sel_b_q     <= '0;
            sel_w_q     <= '0;
            imm_q       <= '0;
            jmp_q       <= '0;
        end else if (bus.flush) begin
            full <= 1'b0;
        end else if (accept) begin
            full        <= 1'b1;
            sel_data_q  <= dec_sel_data;
            write_en_q  <= dec_write_en;
            alu_op_q    <= dec_alu_op;
            is_branch_q <= dec_is_branch;
            sel_b_q     <= bus.INS[RW-1:0];
            sel_a_q     <= bus.INS[2*RW-1:RW];
            sel_w_q     <= bus.INS[3*RW-1:2*RW];
            imm_q       <= bus.INS[DW-1:0];
            jmp_q       <= bus.INS[2*DW-1:DW];
        end else if (issue) begin
            full <= 1'b0;
        end
    end

`ifdef INS_DEC_SCOREBOARD_EN
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_set;
    logic [NREG-1:0] pending_clr;
    logic            reads_regs;

    assign reads_regs = write_en_q & ~sel_data_q;

    // Set/clear masks for this cycle's issue and write-back
    always_comb begin
        pending_set = '0;
        pending_clr = '0;
        if (issue && write_en_q) begin
            pending_set[sel_w_q] = 1'b1;
        end
        if (bus.wb_valid) begin
            pending_clr[bus.WB_SEL] = 1'b1;
        end
    end

    // Pending vector; a same-cycle set overrides the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~pending_clr) | pending_set;
        end
    end

    // Only registered pending bits are consulted: no write-back bypass
    assign stall_i = full &
                     ((reads_regs & (pending[sel_a_q] | pending[sel_b_q])) |
                      (write_en_q & pending[sel_w_q]));
`else
    logic unused_wb;
    assign unused_wb = ^{bus.wb_valid, bus.WB_SEL};
    assign stall_i   = 1'b0;
`endif

    assign bus.in_ready  = in_ready_i;
    assign bus.out_valid = out_valid_i;
    assign bus.stall     = stall_i;
    assign bus.sel_data  = sel_data_q;
    assign bus.write_en  = write_en_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.is_branch = is_branch_q;
    assign bus.SEL_A     = sel_a_q;
    assign bus.SEL_B     = sel_b_q;
    assign bus.SEL_W     = sel_w_q;
    assign bus.IMM       = imm_q;
    assign bus.JMP       = jmp_q;
endmodule

// File: tb/tb_ins_dec_stage.sv
// tb_ins_dec_stage: directed stimulus for ins_dec_stage with a queue-based
// reference model checked every cycle, plus literal expectations.
// Follows INS_DEC_SCOREBOARD_EN the same way the design does.
module tb_ins_dec_stage;
    localparam int DW    = 4;
    localparam int RW    = 2;
    localparam int INS_W = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ins_dec_stage_if #(.DW(DW), .RW(RW), .INS_W(INS_W)) bus ();

    ins_dec_stage #(.DW(DW), .RW(RW), .INS_W(INS_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       sel_data;
        logic       write_en;
        logic       alu_op;
        logic       is_branch;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] w;
        logic [3:0] imm;
        logic [3:0] jmp;
    } dec_t;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    logic [15:0] held[$];
    bit   [3:0]  pend;
    logic [3:0]  issued[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Field meaning straight from the opcode table
    function automatic dec_t decode(input logic [15:0] ins);
        dec_t d;
        logic [2:0] op;
        op          = ins[10:8];
        d.sel_data  = op[1];
        d.alu_op    = op[0];
        d.is_branch = (op == 3'b100);
        d.write_en  = !(op == 3'b100 || op == 3'b011);
        d.b         = ins[1:0];
        d.a         = ins[3:2];
        d.w         = ins[5:4];
        d.imm       = ins[3:0];
        d.jmp       = ins[7:4];
        return d;
    endfunction

    function automatic dec_t dut_fields();
        dec_t d;
        d = {bus.sel_data, bus.write_en, bus.alu_op, bus.is_branch,
             bus.SEL_A, bus.SEL_B, bus.SEL_W, bus.IMM, bus.JMP};
        return d;
    endfunction

    function automatic logic m_stall();
`ifdef INS_DEC_SCOREBOARD_EN
        dec_t d;
        logic reads;
        if (held.size() == 0) return 1'b0;
        d     = decode(held[0]);
        reads = d.write_en && !d.sel_data;
        return (reads && (pend[d.a] || pend[d.b])) || (d.write_en && pend[d.w]);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic m_out_valid();
        return (held.size() != 0) && !m_stall();
    endfunction

    function automatic logic m_in_ready();
        return !rst && ((held.size() == 0) || (m_out_valid() && bus.out_ready));
    endfunction

    task automatic model_step();
        logic ir;
        logic iss;
        dec_t d;
        if (rst) begin
            held.delete();
            pend = '0;
        end else begin
            ir  = m_in_ready();
            iss = m_out_valid() && bus.out_ready && !bus.flush;
            if (bus.wb_valid) pend[bus.WB_SEL] = 1'b0;
            if (iss) begin
                d = decode(held[0]);
                if (d.write_en) pend[d.w] = 1'b1;
                void'(held.pop_front());
            end
            if (bus.flush) held.delete();
            else if (bus.in_valid && ir) held.push_back(bus.INS);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Cycle-by-cycle comparison against the model, mid low phase
    initial forever begin
        @(negedge clk);
        #2;
        if (chk_en) begin
            check("in_ready", 32'(bus.in_ready), 32'(m_in_ready()));
            check("out_valid", 32'(bus.out_valid), 32'(m_out_valid()));
            check("stall", 32'(bus.stall), 32'(m_stall()));
            if (held.size() != 0)
                check("fields", 32'(dut_fields()), 32'(decode(held[0])));
            if (bus.out_valid && bus.out_ready && !bus.flush && !rst)
                issued.push_back(bus.IMM);
        end
    end

    task automatic drive(input logic [15:0] ins, input logic iv, input logic ordy,
                         input logic fl = 1'b0, input logic wbv = 1'b0,
                         input logic [1:0] wbs = 2'd0, input logic r = 1'b0);
        @(negedge clk);
        rst          = r;
        bus.INS      = ins;
        bus.in_valid = iv;
        bus.out_ready = ordy;
        bus.flush    = fl;
        bus.wb_valid = wbv;
        bus.WB_SEL   = wbs;
        #3;
    endtask

    initial begin
        rst           = 1'b1;
        bus.INS       = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.WB_SEL    = '0;
        chk_en        = 1'b1;

        // Reset state
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        drive(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        drive(16'h0000, 1'b0, 1'b1);
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_rst_fields", 32'(dut_fields()), 32'd0);

        // Decode
        drive(16'h07FF, 1'b1, 1'b1);
        drive(16'h0555, 1'b1, 1'b1);
        check("dec_07ff_valid", 32'(bus.out_valid), 32'd1);
        check("dec_07ff_fields", 32'(dut_fields()), 32'({4'b1110, 2'd3, 2'd3, 2'd3, 4'hF, 4'hF}));
        drive(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
        check("dec_0555_fields", 32'(dut_fields()), 32'({4'b0110, 2'd1, 2'd1, 2'd1, 4'h5, 4'h5}));
        drive(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1);

        // Opcode classes
        drive(16'h0400, 1'b1, 1'b1);
        drive(16'h0300, 1'b1, 1'b1);
        check("br_write_en", 32'(bus.write_en), 32'd0);
        check("br_is_branch", 32'(bus.is_branch), 32'd1);
        drive(16'h0000, 1'b1, 1'b1);
        check("noop_we_br", 32'({bus.write_en, bus.is_branch}), 32'd0);
        drive(16'h02AA, 1'b1, 1'b1);
        check("op000_we", 32'({bus.out_valid, bus.write_en}), 32'd3);
        drive(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
        check("op010_we", 32'({bus.out_valid, bus.write_en, bus.sel_data}), 32'd7);
        drive(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2);

        // Backpressure then release
        issued.delete();
        drive(16'h0301, 1'b1, 1'b0);
        repeat (3) drive(16'h0302, 1'b1, 1'b0);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_hold", 32'({bus.out_valid, bus.IMM}), 32'h11);
        drive(16'h0302, 1'b1, 1'b1);
        drive(16'h0303, 1'b1, 1'b1);
        drive(16'h0304, 1'b1, 1'b1);
        drive(16'h0000, 1'b0, 1'b1);
        drive(16'h0000, 1'b0, 1'b1);
        check("bp_count", 32'(issued.size()), 32'd4);
        if (issued.size() == 4)
            check("bp_order", 32'({issued[0], issued[1], issued[2], issued[3]}), 32'h1234);

        // RAW hazard on R2
        drive(16'h0020, 1'b1, 1'b1);
        drive(16'h0008, 1'b1, 1'b1);
        drive(16'h0000, 1'b0, 1'b1);
`ifdef INS_DEC_SCOREBOARD_EN
        check("raw_stall", 32'({bus.stall, bus.out_valid}), 32'd2);
        drive(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2);
        check("raw_wb_cycle", 32'({bus.stall, bus.out_valid}), 32'd2);
        drive(16'h0000, 1'b0, 1'b1);
        check("raw_release", 32'({bus.stall, bus.out_valid}), 32'd1);
`else
        check("raw_no_stall", 32'({bus.stall, bus.out_valid}), 32'd1);
        drive(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2);
        drive(16'h0000, 1'b0, 1'b1);
`endif
        drive(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);

        // Same-cycle set/clear of R2, then reset in the middle of the stall
        drive(16'h0020, 1'b1, 1'b1);
        drive(16'h0008, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2);
        drive(16'h0000, 1'b0, 1'b1);
`ifdef INS_DEC_SCOREBOARD_EN
        check("setclr_stall", 32'(bus.stall), 32'd1);
`else
        check("setclr_no_stall", 32'({bus.stall, bus.out_valid}), 32'd1);
`endif
        drive(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        check("rst_mid_in_ready", 32'(bus.in_ready), 32'd0);
        drive(16'h0000, 1'b0, 1'b1);
        check("rst_mid_clear", 32'({bus.in_ready, bus.out_valid, bus.stall}), 32'd4);
        check("rst_mid_fields", 32'(dut_fields()), 32'd0);
        drive(16'h0008, 1'b1, 1'b1);
        drive(16'h0000, 1'b0, 1'b1);
        check("rst_pend_clear", 32'({bus.out_valid, bus.stall}), 32'd2);
        drive(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);

        // Flush with a same-cycle input
        drive(16'h0020, 1'b1, 1'b0);
        issued.delete();
        drive(16'h0301, 1'b1, 1'b1, 1'b1);
        drive(16'h0000, 1'b0, 1'b1);
        check("flush_empty", 32'({bus.out_valid, bus.in_ready}), 32'd1);
        drive(16'h0008, 1'b1, 1'b1);
        drive(16'h0000, 1'b0, 1'b1);
        check("flush_no_pend", 32'({bus.out_valid, bus.stall}), 32'd2);
        drive(16'h0000, 1'b0, 1'b1);
        check("flush_issue_count", 32'(issued.size()), 32'd1);
        if (issued.size() == 1)
            check("flush_issue_imm", 32'(issued[0]), 32'h8);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ins_dec_stage.md
# ins_dec_stage

Registered, parametrised instruction-decode stage for the 4-bit CPU. It sits between the fetch/instruction-memory output and the datapath. It decodes the same opcode/field layout as the combinational decoder, now generalised in data width and register count. It adds a valid/ready handshake, a pipeline register, a flush path for taken branches, and an optional register scoreboard that stalls read-after-write and write-after-write hazards until write-back.

## Interface
- DW, 4: data/immediate width; IMM and JMP are DW bits.
- RW, 2: register-select width; register file holds 2**RW registers. Constraint: 3*RW <= 2*DW.
- INS_W, 16: instruction width. Constraint: INS_W >= 2*DW+3. Bits above 2*DW+2 are ignored.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- INS  in  INS_W  instruction word.
- in_valid  in  1  INS is valid.
- in_ready  out  1  stage accepts INS this cycle.
- flush  in  1  discard the held instruction (taken branch).
- out_valid  out  1  decoded fields valid for issue.
- out_ready  in  1  datapath accepts the issued instruction.
- sel_data, write_en, alu_op, is_branch  out  1 each  decoded controls.
- SEL_A, SEL_B, SEL_W  out  RW each  register selects.
- IMM, JMP  out  DW each  immediate and jump target.
- stall  out  1  held instruction is blocked by the scoreboard.
- wb_valid  in  1  write-back of register WB_SEL is completing.
- WB_SEL  in  RW  write-back register index.

## Operation
- Opcode field: OP = INS[2*DW+2:2*DW], written as bits {o2,o1,o0}.
- sel_data = o1.
- alu_op = o0.
- is_branch = (OP == 3'b100).
- write_en = (o2 | ~o1 | ~o0) & (~o2 | o1 | o0). It is 0 only for branch (100) and noop (011).
- SEL_B = INS[RW-1:0]; SEL_A = INS[2*RW-1:RW]; SEL_W = INS[3*RW-1:2*RW].
- IMM = INS[DW-1:0]; JMP = INS[2*DW-1:DW].
- All decoded outputs are registered. They are captured together with a `full` flag on input acceptance and hold their values while out_valid & ~out_ready.
- in_ready = ~full | (out_valid & out_ready). Accept condition: in_valid & in_ready.
- out_valid = full & ~stall.
- Register read set: an instruction with write_en=1 and sel_data=0 reads SEL_A and SEL_B. All other instructions read no register.
- Scoreboard: a 2**RW-bit pending vector.
  - Set pending[SEL_W] on issue (out_valid & out_ready & write_en).
  - Clear pending[WB_SEL] on wb_valid.
  - Set and clear of the same index in the same cycle: set wins.
- stall = full & (pending[SEL_A] | pending[SEL_B] for a reading op, or pending[SEL_W] for a writing op). Only registered pending bits are checked; there is no write-back bypass.
- flush: full clears next edge. The held instruction is not issued. A same-cycle input acceptance is dropped (flush wins). The scoreboard is unaffected.
- rst: full=0, pending=0, all decoded outputs 0, out_valid=0, stall=0. in_ready=0 while rst=1.

## Timing
- Latency 1: INS accepted at edge N appears on outputs with out_valid=1 during cycle N+1, if no hazard.
- Throughput: 1 instruction/cycle when out_ready=1 and no hazard.
- A hazard-stalled instruction issues no earlier than the cycle after the edge that clears its blocking pending bit.
- Outputs are stable while out_valid=1 and out_ready=0. out_valid never drops without an issue, flush, or rst.
- Reset mid-stall or mid-backpressure: state is discarded, and the first cycle after rst falls has in_ready=1.

## Configuration
- INS_DEC_SCOREBOARD_EN defined: scoreboard and hazard stall are present as described above.
- INS_DEC_SCOREBOARD_EN not defined: no pending vector; stall is tied to 0; out_valid = full; wb_valid and WB_SEL are ignored; a plain registered pipeline stage remains.

## Test plan
All scenarios use defaults DW=4, RW=2, INS_W=16, with INS_DEC_SCOREBOARD_EN defined unless noted.
- Decode: after rst, INS=16'h07FF, in_valid=1, out_ready=1. Next cycle: out_valid=1, sel_data=1, write_en=1, alu_op=1, is_branch=0, SEL_A=SEL_B=SEL_W=3, IMM=JMP=4'hF. INS=16'h0555 gives sel_data=0, alu_op=1, write_en=1, fields 1 and 4'h5.
- Opcode classes: 16'h0400 gives write_en=0, is_branch=1, and sets no pending bit. 16'h0300 gives write_en=0, is_branch=0. 16'h0000 and 16'h02AA give write_en=1.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1. Then in_ready=0 and outputs are unchanged. On release, one instruction transfers per cycle with no loss or duplication.
- RAW hazard: issue 16'h0020 (write R2), then 16'h0008 (reads A=R2). The second instruction has stall=1 and out_valid=0. Pulse wb_valid=1 with WB_SEL=2. out_valid=1 the following cycle. Same-cycle set/clear of R2 leaves pending[2]=1.
- Flush: flush=1 while holding an instruction, with in_valid=1 on the same cycle. Next cycle out_valid=0 and full=0, pending is unchanged, and neither instruction issues.
- Reset/config: assert rst during a stall; all outputs and pending clear. With the macro undefined, the RAW sequence issues back-to-back and stall stays 0.
